// File: rtl/int_multiplier_seq.sv
// Sequential radix-2 shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH bits in WIDTH cycles.
// Optional two's-complement mode when SIGNED_MUL_EN is defined (adds the Signed_Op port).
module int_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SIGNED_MUL_EN
  input  logic             Signed_Op,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product_Hi,
  output logic [WIDTH-1:0] Product_Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] prod_hi_q;
  logic [WIDTH-1:0] prod_lo_q;
`ifdef SIGNED_MUL_EN
  logic             sign_q;
`endif

  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH:0]   shifted_d;
  logic [WIDTH-1:0]   acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_d;
  logic [2*WIDTH-1:0] result_d;
  logic [WIDTH-1:0]   opa_d;
  logic [WIDTH-1:0]   opb_d;
  logic               sign_d;
  logic               last_d;

  // The carry out of the add lands in the top bit and is shifted straight into
  // acc_hi, so it never needs to persist across cycles.
  always_comb begin
    sum_d = {1'b0, acc_hi_q};
    if (acc_lo_q[0]) begin
      sum_d = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    end
    shifted_d = {sum_d, acc_lo_q} >> 1;
    acc_hi_d  = shifted_d[2*WIDTH-1:WIDTH];
    acc_lo_d  = shifted_d[WIDTH-1:0];
    result_d  = shifted_d[2*WIDTH-1:0];
`ifdef SIGNED_MUL_EN
    if (sign_q) begin
      result_d = '0 - shifted_d[2*WIDTH-1:0];
    end
`endif
    last_d = (count_q == CW'(WIDTH - 1));
  end

  always_comb begin
    opa_d  = A;
    opb_d  = B;
    sign_d = 1'b0;
`ifdef SIGNED_MUL_EN
    if (Signed_Op) begin
      if (A[WIDTH-1]) opa_d = '0 - A;
      if (B[WIDTH-1]) opb_d = '0 - B;
      sign_d = A[WIDTH-1] ^ B[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
`ifdef SIGNED_MUL_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            mcand_q  <= opa_d;
            acc_hi_q <= '0;
            acc_lo_q <= opb_d;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
`ifdef SIGNED_MUL_EN
            sign_q   <= sign_d;
`endif
          end
        end
        CALC: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          count_q  <= count_q + 1'b1;
          done_q   <= last_d;
          if (last_d) begin
            prod_hi_q <= result_d[2*WIDTH-1:WIDTH];
            prod_lo_q <= result_d[WIDTH-1:0];
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // sign_d is only consumed in the signed build
  logic unused_sign;
  assign unused_sign = sign_d;

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Product_Hi = prod_hi_q;
  assign Product_Lo = prod_lo_q;

endmodule
